interp_table_loader: RTL and testbench
======================================

Name: interp_table_loader

Overview:
Writer side of the interpolation data memory. Accepts a word stream over a valid/ready handshake and writes it into RAM in the layout the interpolation datapath reads:
- point count m at M_ADDR
- time samples at T_BASE..
- U vectors at U_BASE + j*U_STRIDE.

It sits between the host/input loader and the shared RAM write port. Its done pulse drives the interpolation module's init_sg.

Parameters:
WORD_SIZE, 16, data word width (signed fixed point, 7 fractional bits)
ADDRESS_WIDTH, 16, RAM address width
M_ADDR, 0, address of point count m
T_BASE, 1, address of t0
U_BASE, 6, address of u0 element 0
U_STRIDE, 512, address distance between consecutive U vectors
MAX_POINTS, 5, maximum m (T_BASE+MAX_POINTS-1 < U_BASE)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  begin a load; sampled only in IDLE/DONE/ERR
vec_len  in  10  words per U vector, latched on start
in_valid  in  1  in_data valid
in_data  in  WORD_SIZE  stream word
in_ready  out  1  loader can accept in_data this cycle
ram_wr_en  out  1  RAM write strobe
ram_wr_add  out  ADDRESS_WIDTH  RAM write address
ram_wr_data  out  WORD_SIZE  RAM write data
busy  out  1  load in progress
done  out  1  one-cycle pulse, load completed successfully
error  out  1  sticky; cleared by next accepted start

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters and latched vec_len/m cleared. Reset mid-load abandons the load; no further writes.
- Stream order: m, then t0..t(m-1), then U0[0..vec_len-1] .. U(m-1)[0..vec_len-1].
  - Total words = 1 + m + m*vec_len.
- Handshake: a word transfers when in_valid & in_ready on a rising edge.
  - in_ready=1 in LOAD_M/LOAD_T/LOAD_U, else 0.
  - in_data must be ignored when no transfer occurs.
- Write latency: exactly 1 cycle. The cycle after a transfer, ram_wr_en=1 with registered address/data. Otherwise ram_wr_en=0, address/data hold their last values.
  - Throughput is 1 word/cycle with back-to-back transfers.
- Addresses:
  - m → M_ADDR
  - t_i → T_BASE+i
  - U_j[i] → U_BASE + j*U_STRIDE + i
  - Compute incrementally (row base += U_STRIDE, column counter); no multiplier.
- FSM:
  - IDLE: start → capture vec_len, clear error, busy=1 → LOAD_M.
    - If vec_len==0 or vec_len>U_STRIDE → ERR instead.
  - LOAD_M: on transfer, latch m.
    - m==0 or m>MAX_POINTS (unsigned) → ERR, with no write issued for m.
    - Otherwise write m → LOAD_T.
  - LOAD_T: on transfer, write t_i.
    - For i>0, if t_i <= t_(i-1) (signed compare) → ERR; the offending word is not written.
    - After t_(m-1) → LOAD_U.
  - LOAD_U: on transfer, write element. After U_(m-1)[vec_len-1] → DONE.
  - DONE: done=1 for exactly the cycle of entry, coincident with the final ram_wr_en. busy=0. start → as IDLE.
  - ERR: error=1 (sticky), busy=0, no writes, in_ready=0. start → as IDLE.
- start while busy is ignored. in_valid outside load states is ignored.
- Counters are wide enough for m ≤ MAX_POINTS and vec_len ≤ U_STRIDE. No wrap-around is possible with legal parameters.

Test Plan:
- Reset, then start with vec_len=2 and stream 3, 0x0000, 0x0080, 0x0100, 0x0A00, 0x0B00, 0x0C00, 0x0D00, 0x0E00, 0x0F00 back-to-back → writes (0,3), (1,0x0000), (2,0x0080), (3,0x0100), (6,0x0A00), (7,0x0B00), (518,0x0C00), (519,0x0D00), (1030,0x0E00), (1031,0x0F00). Each write 1 cycle after its transfer; done pulses once with the last write.
- Same stream with in_valid toggling every other cycle → identical write sequence; ram_wr_en high only in cycles following a transfer.
- m=6 with MAX_POINTS=5 → no write, error=1 and busy=0 next cycle, in_ready=0. A new start with vec_len=1 clears error.
- m=2, t stream 0x0100, 0x0080 → writes (0,2), (1,0x0100) only; error=1.
- Start with vec_len=0 → ERR immediately, zero writes. vec_len=512 with m=1 → U0 written at addresses 6..517, done pulses.
- Drop rst low during LOAD_U → all outputs 0 asynchronously. After release, state is IDLE and there are no writes until a new start.

Source files
------------

// File: rtl/interp_table_loader_if.sv
// Stream-in and RAM-write signals of the interpolation table loader.
// master: loader side, slave: host/RAM side.
interface interp_table_loader_if #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 16
);
  logic                     in_valid;
  logic [WORD_SIZE-1:0]     in_data;
  logic                     in_ready;
  logic                     ram_wr_en;
  logic [ADDRESS_WIDTH-1:0] ram_wr_add;
  logic [WORD_SIZE-1:0]     ram_wr_data;

  modport master (
    input  in_valid, in_data,
    output in_ready, ram_wr_en, ram_wr_add, ram_wr_data
  );

  modport slave (
    output in_valid, in_data,
    input  in_ready, ram_wr_en, ram_wr_add, ram_wr_data
  );
endinterface

// File: rtl/interp_table_loader.sv
// Writes the m / t / U word stream into the interpolation RAM layout.
// state    | meaning
// S_IDLE   | waiting for start
// S_LOAD_M | expecting point count m
// S_LOAD_T | expecting time samples t0..t(m-1), strictly increasing
// S_LOAD_U | expecting U vectors, row by row
// S_DONE   | load complete (done pulses on entry with the last write)
// S_ERR    | bad vec_len, bad m or non-increasing t; sticky until start
module interp_table_loader #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int M_ADDR        = 0,
  parameter int T_BASE        = 1,
  parameter int U_BASE        = 6,
  parameter int U_STRIDE      = 512,
  parameter int MAX_POINTS    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [9:0]            vec_len,
  interp_table_loader_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam int PW = $clog2(MAX_POINTS + 1);
  localparam int CW = 10;
  localparam logic [ADDRESS_WIDTH-1:0] M_A = ADDRESS_WIDTH'(M_ADDR);
  localparam logic [ADDRESS_WIDTH-1:0] T_A = ADDRESS_WIDTH'(T_BASE);
  localparam logic [ADDRESS_WIDTH-1:0] U_A = ADDRESS_WIDTH'(U_BASE);
  localparam logic [ADDRESS_WIDTH-1:0] S_A = ADDRESS_WIDTH'(U_STRIDE);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_M, S_LOAD_T, S_LOAD_U, S_DONE, S_ERR
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]               vec_len_q, col_left;
  logic [PW-1:0]               m_q, t_idx, row_left;
  logic signed [WORD_SIZE-1:0] t_prev;
  logic [ADDRESS_WIDTH-1:0]    row_base, u_addr;

  logic                     xfer, start_ok, len_bad, m_bad, t_bad, t_last, u_last;
  logic                     wr_req;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic                     wr_en_q;
  logic [ADDRESS_WIDTH-1:0] wr_add_q;
  logic [WORD_SIZE-1:0]     wr_data_q;

  assign xfer     = bus.in_valid & bus.in_ready;
  assign start_ok = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERR));
  assign len_bad  = (vec_len == '0) || (32'(vec_len) > U_STRIDE);
  assign m_bad    = (bus.in_data == '0) || (32'(bus.in_data) > MAX_POINTS);
  assign t_bad    = (t_idx != '0) && ($signed(bus.in_data) <= t_prev);
  assign t_last   = (t_idx == m_q - PW'(1));
  assign u_last   = (col_left == CW'(1)) && (row_left == PW'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE, S_ERR:
        if (start) state_nx = len_bad ? S_ERR : S_LOAD_M;
      S_LOAD_M:
        if (xfer) state_nx = m_bad ? S_ERR : S_LOAD_T;
      S_LOAD_T:
        if (xfer) begin
          if (t_bad)       state_nx = S_ERR;
          else if (t_last) state_nx = S_LOAD_U;
        end
      S_LOAD_U:
        if (xfer && u_last) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    busy         = 1'b0;
    error        = (state == S_ERR);
    done         = (state == S_DONE) & wr_en_q;
    wr_req       = 1'b0;
    wr_addr      = wr_add_q;
    case (state)
      S_LOAD_M: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        wr_req       = xfer & ~m_bad;
        wr_addr      = M_A;
      end
      S_LOAD_T: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        wr_req       = xfer & ~t_bad;
        wr_addr      = T_A + ADDRESS_WIDTH'(t_idx);
      end
      S_LOAD_U: begin
        bus.in_ready = 1'b1;
        busy         = 1'b1;
        wr_req       = xfer;
        wr_addr      = u_addr;
      end
      default: ;
    endcase
  end

  // Walk counters: column/row counts go down to a terminal count of 1,
  // addresses advance by +1 per element and +U_STRIDE per row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vec_len_q <= '0;
      col_left  <= '0;
      m_q       <= '0;
      t_idx     <= '0;
      row_left  <= '0;
      t_prev    <= '0;
      row_base  <= '0;
      u_addr    <= '0;
    end else begin
      if (start_ok) begin
        vec_len_q <= vec_len;
        t_idx     <= '0;
      end
      case (state)
        S_LOAD_M:
          if (xfer && !m_bad) begin
            m_q      <= bus.in_data[PW-1:0];
            row_left <= bus.in_data[PW-1:0];
            col_left <= vec_len_q;
            row_base <= U_A;
            u_addr   <= U_A;
            t_idx    <= '0;
          end
        S_LOAD_T:
          if (xfer && !t_bad) begin
            t_prev <= $signed(bus.in_data);
            t_idx  <= t_idx + PW'(1);
          end
        S_LOAD_U:
          if (xfer) begin
            if (col_left == CW'(1)) begin
              col_left <= vec_len_q;
              row_left <= row_left - PW'(1);
              row_base <= row_base + S_A;
              u_addr   <= row_base + S_A;
            end else begin
              col_left <= col_left - CW'(1);
              u_addr   <= u_addr + ADDRESS_WIDTH'(1);
            end
          end
        default: ;
      endcase
    end
  end

  // Address/data hold their last values between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_add_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= wr_req;
      if (wr_req) begin
        wr_add_q  <= wr_addr;
        wr_data_q <= bus.in_data;
      end
    end
  end

  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_wr_add  = wr_add_q;
  assign bus.ram_wr_data = wr_data_q;
endmodule

// File: tb/tb_interp_table_loader.sv
// Directed bench for interp_table_loader: logs RAM writes and compares
// them with hand-written expected write lists.
module tb_interp_table_loader;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] vec_len;
  logic       busy, done, error;

  interp_table_loader_if #(.WORD_SIZE(16), .ADDRESS_WIDTH(16)) bus ();

  interp_table_loader dut (
    .clk     (clk),
    .rst     (rst_n),
    .start   (start),
    .vec_len (vec_len),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] wa[$], wd[$], ea[$], ed[$], stim[$];
  int  done_cnt, done_wr, lat_err;
  bit  lat_chk;
  logic xfer_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) xfer_q <= bus.in_valid & bus.in_ready;

  always @(negedge clk) begin
    if (bus.ram_wr_en === 1'b1) begin
      wa.push_back(bus.ram_wr_add);
      wd.push_back(bus.ram_wr_data);
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (bus.ram_wr_en === 1'b1) done_wr++;
    end
    if (lat_chk && (bus.ram_wr_en !== xfer_q)) lat_err++;
  end

  task automatic clear_log();
    wa.delete(); wd.delete(); ea.delete(); ed.delete(); stim.delete();
    done_cnt = 0; done_wr = 0; lat_err = 0;
  endtask

  task automatic add_exp(input logic [15:0] a, input logic [15:0] d);
    ea.push_back(a);
    ed.push_back(d);
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_count"}, wa.size(), ea.size());
    n = (wa.size() < ea.size()) ? wa.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_addr%0d", tag, i), wa[i], ea[i]);
      check($sformatf("%s_data%0d", tag, i), wd[i], ed[i]);
    end
  endtask

  task automatic do_start(input logic [9:0] len);
    @(negedge clk);
    start = 1'b1;
    vec_len = len;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Stops early once the loader drops in_ready; gap inserts an idle cycle
  // with junk data before each word.
  task automatic run_stream(input bit gap);
    foreach (stim[i]) begin
      if (gap) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = 16'hDEAD;
      end
      @(negedge clk);
      if (bus.in_ready !== 1'b1) begin
        bus.in_valid = 1'b0;
        break;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = stim[i];
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_main_stream();
    stim = '{16'd3, 16'h0000, 16'h0080, 16'h0100, 16'h0A00, 16'h0B00,
             16'h0C00, 16'h0D00, 16'h0E00, 16'h0F00};
    add_exp(0, 3);       add_exp(1, 16'h0000); add_exp(2, 16'h0080);
    add_exp(3, 16'h0100); add_exp(6, 16'h0A00); add_exp(7, 16'h0B00);
    add_exp(518, 16'h0C00); add_exp(519, 16'h0D00);
    add_exp(1030, 16'h0E00); add_exp(1031, 16'h0F00);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    vec_len = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    lat_chk = 1'b0;
    clear_log();
    wait_cycles(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_ready", bus.in_ready, 0);
    check("rst_wr_en", bus.ram_wr_en, 0);
    check("rst_wr_add", bus.ram_wr_add, 0);
    check("rst_wr_data", bus.ram_wr_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);

    // back-to-back main stream
    clear_log();
    load_main_stream();
    do_start(10'd2);
    check("t1_busy", busy, 1);
    check("t1_ready", bus.in_ready, 1);
    lat_chk = 1'b1;
    run_stream(1'b0);
    wait_cycles(2);
    lat_chk = 1'b0;
    check_writes("t1");
    check("t1_done_cnt", done_cnt, 1);
    check("t1_done_with_wr", done_wr, 1);
    check("t1_latency", lat_err, 0);
    check("t1_busy_end", busy, 0);
    check("t1_error", error, 0);

    // same stream, in_valid every other cycle
    clear_log();
    load_main_stream();
    do_start(10'd2);
    lat_chk = 1'b1;
    run_stream(1'b1);
    wait_cycles(2);
    lat_chk = 1'b0;
    check_writes("t2");
    check("t2_done_cnt", done_cnt, 1);
    check("t2_done_with_wr", done_wr, 1);
    check("t2_latency", lat_err, 0);

    // m above MAX_POINTS
    clear_log();
    do_start(10'd2);
    stim = '{16'd6};
    run_stream(1'b0);
    check("t3_error", error, 1);
    check("t3_busy", busy, 0);
    check("t3_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1234;
    wait_cycles(3);
    bus.in_valid = 1'b0;
    wait_cycles(1);
    check("t3_writes", wa.size(), 0);
    do_start(10'd1);
    check("t3_error_clr", error, 0);
    check("t3_busy_restart", busy, 1);

    // non-increasing t stops the load before the bad word is written
    clear_log();
    stim = '{16'd2, 16'h0100, 16'h0080};
    add_exp(0, 2); add_exp(1, 16'h0100);
    run_stream(1'b0);
    wait_cycles(2);
    check_writes("t4");
    check("t4_error", error, 1);
    check("t4_busy", busy, 0);
    check("t4_done_cnt", done_cnt, 0);

    // vec_len out of range
    clear_log();
    do_start(10'd0);
    check("t5_error_len0", error, 1);
    check("t5_busy_len0", busy, 0);
    check("t5_ready_len0", bus.in_ready, 0);
    stim = '{16'd1};
    run_stream(1'b0);
    wait_cycles(1);
    check("t5_writes", wa.size(), 0);
    do_start(10'd513);
    check("t5_error_len513", error, 1);

    // vec_len = U_STRIDE, m = 1; a start while busy must be ignored
    clear_log();
    do_start(10'd512);
    check("t6_error_clr", error, 0);
    do_start(10'd0);
    check("t6_busy_ignore", busy, 1);
    check("t6_error_ignore", error, 0);
    stim.push_back(16'd1);
    stim.push_back(16'd5);
    add_exp(0, 1);
    add_exp(1, 5);
    for (int i = 0; i < 512; i++) begin
      stim.push_back(16'(i + 16'h0100));
      add_exp(16'(6 + i), 16'(i + 16'h0100));
    end
    run_stream(1'b0);
    wait_cycles(2);
    check_writes("t6");
    check("t6_done_cnt", done_cnt, 1);
    check("t6_error", error, 0);

    // reset in LOAD_U
    clear_log();
    do_start(10'd2);
    stim = '{16'd2, 16'h0010, 16'h0020, 16'h000A, 16'h000B};
    run_stream(1'b0);
    check("t7_wr_before", bus.ram_wr_en, 1);
    check("t7_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_busy", busy, 0);
    check("t7_ready", bus.in_ready, 0);
    check("t7_wr_en", bus.ram_wr_en, 0);
    check("t7_wr_add", bus.ram_wr_add, 0);
    check("t7_wr_data", bus.ram_wr_data, 0);
    check("t7_error", error, 0);
    check("t7_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wa.delete(); wd.delete();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0055;
    wait_cycles(5);
    check("t7_ready_after", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    wait_cycles(1);
    check("t7_writes_after", wa.size(), 0);
    check("t7_busy_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
